// File: rtl/apb_cmd_master.sv
// APB requester: takes single read/write commands on a valid/ready port and
// runs each through SETUP/ACCESS, returning read data or a timeout error.
module apb_cmd_master #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] PADDR_o,
    output logic [DATA_W-1:0] PWDATA_o,
    output logic              PWRITE_o,
    output logic              PSELx_o,
    output logic              PENABLE_o,
    input  logic [DATA_W-1:0] PRDATA_i,
    input  logic              PREADY_i
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t              state_q, state_d;
    logic [7:0]          waitCnt_q, waitCnt_d;
    logic [ADDR_W-1:0]   paddr_q, paddr_d;
    logic [DATA_W-1:0]   pwdata_q, pwdata_d;
    logic                pwrite_q, pwrite_d;
    logic                psel_q, psel_d;
    logic                penable_q, penable_d;
    logic                cmdReady_q, cmdReady_d;
    logic                rspValid_q, rspValid_d;
    logic [DATA_W-1:0]   rspRdata_q, rspRdata_d;
    logic                rspErr_q, rspErr_d;
    logic [7:0]          waitInc;
    logic                timeoutHit;

    // Saturating wait count; the abort fires on the edge where it would reach TIMEOUT.
    assign waitInc    = (waitCnt_q == 8'hFF) ? waitCnt_q : waitCnt_q + 8'd1;
    assign timeoutHit = (TIMEOUT != 0) && (32'(waitInc) >= TIMEOUT);

    always_comb begin
        state_d    = state_q;
        waitCnt_d  = waitCnt_q;
        paddr_d    = paddr_q;
        pwdata_d   = pwdata_q;
        pwrite_d   = pwrite_q;
        rspValid_d = 1'b0;
        rspRdata_d = rspRdata_q;
        rspErr_d   = rspErr_q;

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    paddr_d   = cmd_addr;
                    pwdata_d  = cmd_wdata;
                    pwrite_d  = cmd_write;
                    waitCnt_d = 8'd0;
                    state_d   = SETUP;
                end
            end
            SETUP: begin
                state_d = ACCESS;
            end
            ACCESS: begin
                if (PREADY_i) begin
                    rspValid_d = 1'b1;
                    rspErr_d   = 1'b0;
                    rspRdata_d = pwrite_q ? '0 : PRDATA_i;
                    state_d    = IDLE;
                end else begin
                    waitCnt_d = waitInc;
                    if (timeoutHit) begin
                        rspValid_d = 1'b1;
                        rspErr_d   = 1'b1;
                        rspRdata_d = '0;
                        state_d    = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Bus controls are decoded from the next state so they leave the flops aligned with it.
        psel_d     = (state_d != IDLE);
        penable_d  = (state_d == ACCESS);
        cmdReady_d = (state_d == IDLE);
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q    <= IDLE;
            waitCnt_q  <= 8'd0;
            paddr_q    <= '0;
            pwdata_q   <= '0;
            pwrite_q   <= 1'b0;
            psel_q     <= 1'b0;
            penable_q  <= 1'b0;
            cmdReady_q <= 1'b1;
            rspValid_q <= 1'b0;
            rspRdata_q <= '0;
            rspErr_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            waitCnt_q  <= waitCnt_d;
            paddr_q    <= paddr_d;
            pwdata_q   <= pwdata_d;
            pwrite_q   <= pwrite_d;
            psel_q     <= psel_d;
            penable_q  <= penable_d;
            cmdReady_q <= cmdReady_d;
            rspValid_q <= rspValid_d;
            rspRdata_q <= rspRdata_d;
            rspErr_q   <= rspErr_d;
        end
    end

    assign cmd_ready = cmdReady_q;
    assign rsp_valid = rspValid_q;
    assign rsp_rdata = rspRdata_q;
    assign rsp_err   = rspErr_q;
    assign PADDR_o   = paddr_q;
    assign PWDATA_o  = pwdata_q;
    assign PWRITE_o  = pwrite_q;
    assign PSELx_o   = psel_q;
    assign PENABLE_o = penable_q;

endmodule
